// File: rtl/link_state_monitor.sv
// link_state_monitor: qualifies the filtered LINK_ON level into a
// stable link status with up/down event pulses and a drop counter.
module link_state_monitor #(
  parameter int unsigned UP_CYCLES   = 25000,
  parameter int unsigned DOWN_CYCLES = 250,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       link_on,
  input  logic       clr_cnt,
  output logic       link_up,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic [7:0] drop_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_DOWN = 2'd0,
    S_QUAL = 2'd1,
    S_UP   = 2'd2,
    S_HOLD = 2'd3
  } st_t;

  localparam logic [CNT_W-1:0] UP_LAST = CNT_W'(UP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DN_LAST = CNT_W'(DOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  st_t             st;
  logic [CNT_W-1:0] cnt;

  assign state = st;

  // Link FSM: qualification counter, status, pulses and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= S_DOWN;
      cnt        <= '0;
      link_up    <= 1'b0;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      if (clr_cnt)
        drop_cnt <= 8'd0;
      unique case (st)
        S_DOWN: begin
          if (link_on) begin
            st  <= S_QUAL;
            cnt <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        S_QUAL: begin
          if (!link_on) begin
            st  <= S_DOWN;
            cnt <= '0;
          end else if (cnt == UP_LAST) begin
            st       <= S_UP;
            cnt      <= '0;
            link_up  <= 1'b1;
            up_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_UP: begin
          if (!link_on) begin
            st  <= S_HOLD;
            cnt <= CNT_ONE;
          end
        end
        S_HOLD: begin
          if (link_on) begin
            st  <= S_UP;
            cnt <= '0;
          end else if (cnt == DN_LAST) begin
            st         <= S_DOWN;
            cnt        <= '0;
            link_up    <= 1'b0;
            down_pulse <= 1'b1;
            if (clr_cnt)
              drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF)
              drop_cnt <= drop_cnt + 8'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          st  <= S_DOWN;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_state_monitor.sv
// tb_link_state_monitor: directed vectors for link_state_monitor
// with UP_CYCLES=8, DOWN_CYCLES=4.
module tb_link_state_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       link_on = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       link_up;
  logic       up_pulse;
  logic       down_pulse;
  logic [7:0] drop_cnt;
  logic [1:0] state;

  int n_chk = 0;
  int n_err = 0;
  logic seen;

  link_state_monitor #(
    .UP_CYCLES(8),
    .DOWN_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .link_on(link_on),
    .clr_cnt(clr_cnt),
    .link_up(link_up),
    .up_pulse(up_pulse),
    .down_pulse(down_pulse),
    .drop_cnt(drop_cnt),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic updown();
    link_on = 1'b1;
    ticks(8);
    link_on = 1'b0;
    ticks(4);
  endtask

  // Pulses must never coincide.
  always @(negedge clk)
    if (!rst) chk("excl", {31'd0, up_pulse & down_pulse}, 32'd0);

  initial begin
    // Reset with link_on high
    link_on = 1'b1;
    ticks(3);
    chk("rst_up",    {31'd0, link_up},    32'd0);
    chk("rst_upp",   {31'd0, up_pulse},   32'd0);
    chk("rst_dnp",   {31'd0, down_pulse}, 32'd0);
    chk("rst_drop",  {24'd0, drop_cnt},   32'd0);
    chk("rst_state", {30'd0, state},      32'd0);
    rst = 1'b0;
    ticks(7);
    chk("q7_state", {30'd0, state},   32'd1);
    chk("q7_up",    {31'd0, link_up}, 32'd0);
    tick();
    chk("q8_up",    {31'd0, link_up},  32'd1);
    chk("q8_upp",   {31'd0, up_pulse}, 32'd1);
    chk("q8_state", {30'd0, state},    32'd2);
    tick();
    chk("q9_upp", {31'd0, up_pulse}, 32'd0);
    chk("q9_up",  {31'd0, link_up},  32'd1);

    // Glitch while up
    link_on = 1'b0;
    ticks(3);
    chk("g_state", {30'd0, state},   32'd3);
    chk("g_up",    {31'd0, link_up}, 32'd1);
    link_on = 1'b1;
    tick();
    chk("g_back",  {30'd0, state},      32'd2);
    chk("g_dnp",   {31'd0, down_pulse}, 32'd0);
    chk("g_drop",  {24'd0, drop_cnt},   32'd0);
    chk("g_up2",   {31'd0, link_up},    32'd1);

    // Link drop
    link_on = 1'b0;
    ticks(3);
    chk("d3_up",  {31'd0, link_up},    32'd1);
    chk("d3_dnp", {31'd0, down_pulse}, 32'd0);
    tick();
    chk("d4_up",    {31'd0, link_up},    32'd0);
    chk("d4_dnp",   {31'd0, down_pulse}, 32'd1);
    chk("d4_drop",  {24'd0, drop_cnt},   32'd1);
    chk("d4_state", {30'd0, state},      32'd0);
    tick();
    chk("d5_dnp", {31'd0, down_pulse}, 32'd0);

    // Aborted qualification
    link_on = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      seen |= up_pulse;
    end
    chk("a_nopulse", {31'd0, seen},  32'd0);
    chk("a_state",   {30'd0, state}, 32'd1);
    link_on = 1'b0;
    tick();
    chk("a_abort", {30'd0, state},   32'd0);
    chk("a_up0",   {31'd0, link_up}, 32'd0);
    link_on = 1'b1;
    ticks(7);
    chk("a_q7", {31'd0, link_up}, 32'd0);
    tick();
    chk("a_q8",  {31'd0, link_up},  32'd1);
    chk("a_upp", {31'd0, up_pulse}, 32'd1);
    link_on = 1'b0;
    ticks(4);
    chk("a_drop", {24'd0, drop_cnt}, 32'd2);

    // Saturation
    for (int i = 0; i < 256; i++) updown();
    chk("sat", {24'd0, drop_cnt}, 32'd255);
    updown();
    chk("sat2", {24'd0, drop_cnt}, 32'd255);
    chk("sat_dnp", {31'd0, down_pulse}, 32'd1);

    // Clear coincident with drop
    link_on = 1'b1;
    ticks(8);
    link_on = 1'b0;
    ticks(3);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_drop", {24'd0, drop_cnt}, 32'd1);
    chk("clr_st",   {30'd0, state},    32'd0);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_only", {24'd0, drop_cnt}, 32'd0);

    // Async reset mid-HOLD
    updown();
    chk("h_drop", {24'd0, drop_cnt}, 32'd1);
    link_on = 1'b1;
    ticks(8);
    link_on = 1'b0;
    ticks(2);
    chk("h_state", {30'd0, state}, 32'd3);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_up",    {31'd0, link_up},    32'd0);
    chk("ar_state", {30'd0, state},      32'd0);
    chk("ar_drop",  {24'd0, drop_cnt},   32'd0);
    chk("ar_dnp",   {31'd0, down_pulse}, 32'd0);
    ticks(3);
    chk("ar_dnp2", {31'd0, down_pulse}, 32'd0);
    rst = 1'b0;
    link_on = 1'b1;
    ticks(7);
    chk("rq7", {31'd0, link_up}, 32'd0);
    tick();
    chk("rq8", {31'd0, link_up}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/link_state_monitor.md
# link_state_monitor

Qualifies the filtered LINK_ON level from the LINK_ON input filter on the Receiver Board and turns it into a stable link status.
- Declares link-up only after LINK_ON has been continuously high for a programmable time.
- Declares link-down only after LINK_ON has been continuously low for a programmable time.
- Emits one-cycle up/down event pulses and keeps a saturating count of link drops.
- Sits directly downstream of the filter, in the 25 MHz domain, and feeds the receiver status/control logic.

## Interface
- `UP_CYCLES`, default 25000: consecutive high samples required to declare link-up (1 ms at 25 MHz); legal range 2 … 2^CNT_W-1.
- `DOWN_CYCLES`, default 250: consecutive low samples (while up) required to declare link-down (10 µs); legal range 2 … 2^CNT_W-1.
- `CNT_W`, default 16: width of the internal qualification counter.
- `clk` in 1: 25 MHz system clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `link_on` in 1: filtered LINK_ON level from the upstream filter; already synchronous to `clk`.
- `clr_cnt` in 1: synchronous clear of `drop_cnt`.
- `link_up` out 1: qualified link status, registered.
- `up_pulse` out 1: one-cycle pulse on the DOWN/QUAL→UP transition.
- `down_pulse` out 1: one-cycle pulse on the HOLD→DOWN transition.
- `drop_cnt` out 8: number of link drops, saturating at 255.
- `state` out 2: current FSM state for debug (DOWN=0, QUAL=1, UP=2, HOLD=3).

## Operation
Reset values (async): `state`=DOWN, `cnt`=0, `link_up`=0, `up_pulse`=0, `down_pulse`=0, `drop_cnt`=0.

FSM transitions (all conditions use `link_on` sampled at the edge):
- **DOWN**
  - `link_on`=1: go to QUAL, `cnt`←1.
  - Otherwise: stay, `cnt`←0.
- **QUAL**
  - `link_on`=0: go to DOWN, `cnt`←0, no pulse.
  - `link_on`=1 and `cnt`==UP_CYCLES-1: go to UP, `cnt`←0, `link_up`←1, `up_pulse`←1.
  - Otherwise: `cnt`←`cnt`+1.
- **UP**
  - `link_on`=0: go to HOLD, `cnt`←1.
  - Otherwise: stay.
- **HOLD**
  - `link_on`=1: go to UP, `cnt`←0, no pulse; `link_up` stays 1 throughout HOLD.
  - `link_on`=0 and `cnt`==DOWN_CYCLES-1: go to DOWN, `cnt`←0, `link_up`←0, `down_pulse`←1, increment `drop_cnt`.
  - Otherwise: `cnt`←`cnt`+1.

Pulses:
- `up_pulse` and `down_pulse` are 0 on every cycle except the transition cycles above.
- They are never asserted together.

`drop_cnt` rules:
- Unsigned 8-bit counter; increments by 1 on each down transition.
- At 255 it stays at 255 (no wrap).
- `clr_cnt`=1 with no down transition: `drop_cnt`←0.
- `clr_cnt`=1 and a down transition in the same cycle: `drop_cnt`←1, so the event is not lost.

Other rules:
- `cnt` never exceeds max(UP_CYCLES, DOWN_CYCLES)-1.
- No counting occurs in DOWN or UP.

## Timing
- `link_on` is first sampled high at edge E0 and held high: `link_up` and `up_pulse` go high after edge E0+UP_CYCLES-1. Qualification latency = UP_CYCLES cycles, including E0.
- `link_on` is first sampled low at edge F0 while UP and held low: `link_up`=0, `down_pulse`=1 and updated `drop_cnt` after edge F0+DOWN_CYCLES-1.
- Any opposite sample during QUAL or HOLD aborts the qualification. A new qualification restarts from `cnt`=1 on the next qualifying sample.
- All outputs are registered; nothing is combinational from `link_on`.
- `rst` asserted mid-QUAL or mid-HOLD: immediate return to reset values, no pulse.
- After `rst` deasserts, qualification restarts from DOWN.

## Test plan
Use UP_CYCLES=8, DOWN_CYCLES=4 unless stated.
- **Reset:** assert `rst` while `link_on`=1 → all outputs 0, `state`=0. Release and hold `link_on`=1 → `link_up`=1 and `up_pulse` high for exactly 1 cycle, both after the 8th sampled high.
- **Aborted qualification:** `link_on` high 7 cycles, low 1, high 8 → no `up_pulse` during the first run; `link_up` rises after the 8th sample of the second run.
- **Glitch while up:** from UP, `link_on` low 3 cycles then high → `link_up` stays 1, no `down_pulse`, `drop_cnt` unchanged, `state` returns to 2.
- **Link drop:** from UP, `link_on` low 4 cycles → `link_up`=0, one-cycle `down_pulse`, `drop_cnt` 0→1, `state`=0.
- **Counter saturation and clear:** 256 up/down cycles → `drop_cnt`=255. Next drop → 255. `clr_cnt` coincident with a drop → 1. `clr_cnt` alone → 0.
- **Async reset mid-HOLD:** assert `rst` 2 cycles into HOLD, independent of `clk` → outputs clear immediately, no `down_pulse`, `drop_cnt`=0.
